// File: rtl/shift_rotator.sv
// -----------------------------------------------------------------------------
// shift_rotator
//
// Register of WIDTH bits that can be rotated, logically shifted or
// arithmetically shifted by a programmable amount every clock cycle. It has
// two operating styles:
//   * manual (IDLE): one step per cycle using the live enable/amt/mode inputs;
//   * automatic run (RUN): after a start request, a fixed number of steps is
//     applied using controls captured at the start, then done pulses.
// A parallel load overrides everything and aborts a run in progress.
//
// Build option:
//   SHIFT_MODES_EN  defined   -> mode selects rotate / logical / arithmetic.
//                   undefined -> mode is ignored and every step rotates; no
//                                shift-fill logic is built.
//
// Ports:
//   clk     in   1      clock, all state updates on the rising edge
//   rst_n   in   1      asynchronous active-low reset
//   load    in   1      parallel load of data into q (highest priority)
//   data    in   WIDTH  load value
//   enable  in   2      00 hold, 01 left (to MSB), 10 right (to LSB), 11 hold
//   amt     in   AMT_W  positions moved per step
//   mode    in   2      00 rotate, 01 logical, 10 arithmetic, 11 rotate
//   start   in   1      begin an automatic run of 'steps' steps
//   steps   in   CNT_W  number of steps in the run
//   q       out  WIDTH  registered shift/rotate register
//   busy    out  1      high while the run is in progress
//   done    out  1      one-cycle pulse after the final step of a run
// -----------------------------------------------------------------------------
module shift_rotator #(
  parameter int WIDTH = 100,
  parameter int AMT_W = 7,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] data,
  input  logic [1:0]       enable,
  input  logic [AMT_W-1:0] amt,
  input  logic [1:0]       mode,
  input  logic             start,
  input  logic [CNT_W-1:0] steps,
  output logic [WIDTH-1:0] q,
  output logic             busy,
  output logic             done
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  localparam logic [1:0] EN_LEFT  = 2'b01;
  localparam logic [1:0] EN_RIGHT = 2'b10;
  localparam logic [1:0] MODE_LSH = 2'b01;
  localparam logic [1:0] MODE_ASH = 2'b10;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic             done_q, done_d;
  logic [1:0]       en_cap_q, en_cap_d;
  logic [AMT_W-1:0] amt_cap_q, amt_cap_d;

`ifdef SHIFT_MODES_EN
  logic [1:0]       mode_cap_q, mode_cap_d;
`else
  // mode has no effect in the rotate-only build.
  logic             unused_mode;
  assign unused_mode = ^mode;
`endif

  // ---------------------------------------------------------------------------
  // Step functions
  // ---------------------------------------------------------------------------

  // Rotate by amt mod WIDTH. Shifting a doubled copy lets the bits leaving one
  // end appear at the other end of the selected half.
  function automatic logic [WIDTH-1:0] rot_step(input logic [WIDTH-1:0] v,
                                                input logic             left,
                                                input logic [AMT_W-1:0] a);
    logic [AMT_W-1:0]   eff;
    logic [2*WIDTH-1:0] dbl;
    logic [2*WIDTH-1:0] sh;
    eff = AMT_W'(32'(a) % WIDTH);
    dbl = {v, v};
    if (left) begin
      sh = dbl << eff;
      return sh[2*WIDTH-1:WIDTH];
    end
    sh = dbl >> eff;
    return sh[WIDTH-1:0];
  endfunction

`ifdef SHIFT_MODES_EN
  // Logical shift, zero fill; amounts of WIDTH or more clear the register.
  function automatic logic [WIDTH-1:0] lsh_step(input logic [WIDTH-1:0] v,
                                                input logic             left,
                                                input logic [AMT_W-1:0] a);
    if (32'(a) >= WIDTH) begin
      return '0;
    end
    if (left) begin
      return v << a;
    end
    return v >> a;
  endfunction

  // Arithmetic shift. Right fills with the pre-step MSB (all bits once the
  // amount reaches WIDTH); left is identical to the logical left shift.
  function automatic logic [WIDTH-1:0] ash_step(input logic [WIDTH-1:0] v,
                                                input logic             left,
                                                input logic [AMT_W-1:0] a);
    logic signed [WIDTH-1:0] sv;
    if (left) begin
      return lsh_step(v, 1'b1, a);
    end
    if (32'(a) >= WIDTH) begin
      return {WIDTH{v[WIDTH-1]}};
    end
    sv = v;
    return $unsigned(sv >>> a);
  endfunction
`endif

  // One complete step. Hold directions return the operand untouched; amt = 0
  // falls out naturally from every operator.
  function automatic logic [WIDTH-1:0] do_step(input logic [WIDTH-1:0] v,
                                               input logic [1:0]       en,
                                               input logic [AMT_W-1:0] a,
                                               input logic [1:0]       md);
    logic left;
    if ((en != EN_LEFT) && (en != EN_RIGHT)) begin
      return v;
    end
    left = (en == EN_LEFT);
`ifdef SHIFT_MODES_EN
    case (md)
      MODE_LSH: return lsh_step(v, left, a);
      MODE_ASH: return ash_step(v, left, a);
      default:  return rot_step(v, left, a);
    endcase
`else
    if (md == md) begin
      return rot_step(v, left, a);
    end
    return v;
`endif
  endfunction

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      q_q        <= '0;
      done_q     <= 1'b0;
      en_cap_q   <= '0;
      amt_cap_q  <= '0;
`ifdef SHIFT_MODES_EN
      mode_cap_q <= '0;
`endif
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      q_q        <= q_d;
      done_q     <= done_d;
      en_cap_q   <= en_cap_d;
      amt_cap_q  <= amt_cap_d;
`ifdef SHIFT_MODES_EN
      mode_cap_q <= mode_cap_d;
`endif
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    q_d        = q_q;
    done_d     = 1'b0;
    en_cap_d   = en_cap_q;
    amt_cap_d  = amt_cap_q;
`ifdef SHIFT_MODES_EN
    mode_cap_d = mode_cap_q;
`endif

    if (load) begin
      // Load beats start and aborts any run silently.
      q_d     = data;
      state_d = IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            if (steps != '0) begin
              en_cap_d   = enable;
              amt_cap_d  = amt;
`ifdef SHIFT_MODES_EN
              mode_cap_d = mode;
`endif
              cnt_d      = steps;
              state_d    = RUN;
            end else begin
              // Empty run: nothing moves, completion is reported at once.
              done_d = 1'b1;
            end
          end else begin
            q_d = do_step(q_q, enable, amt, mode);
          end
        end
        RUN: begin
`ifdef SHIFT_MODES_EN
          q_d = do_step(q_q, en_cap_q, amt_cap_q, mode_cap_q);
`else
          q_d = do_step(q_q, en_cap_q, amt_cap_q, 2'b00);
`endif
          if (cnt_q <= CNT_W'(1)) begin
            state_d = IDLE;
            cnt_d   = '0;
            done_d  = 1'b1;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  assign q    = q_q;
  assign busy = (state_q == RUN);
  assign done = done_q;

endmodule

// File: tb/tb_shift_rotator.sv
module tb_shift_rotator;
  localparam int WIDTH = 100;
  localparam int AMT_W = 7;
  localparam int CNT_W = 8;

  logic             clk    = 1'b0;
  logic             rst_n  = 1'b1;
  logic             load   = 1'b0;
  logic [WIDTH-1:0] data   = '0;
  logic [1:0]       enable = 2'b00;
  logic [AMT_W-1:0] amt    = '0;
  logic [1:0]       mode   = 2'b00;
  logic             start  = 1'b0;
  logic [CNT_W-1:0] steps  = '0;
  logic [WIDTH-1:0] q;
  logic             busy;
  logic             done;

  int n_cmp = 0;
  int n_err = 0;

  localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);
  localparam logic [WIDTH-1:0] ONES = {WIDTH{1'b1}};

  shift_rotator #(.WIDTH(WIDTH), .AMT_W(AMT_W), .CNT_W(CNT_W)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .load   (load),
    .data   (data),
    .enable (enable),
    .amt    (amt),
    .mode   (mode),
    .start  (start),
    .steps  (steps),
    .q      (q),
    .busy   (busy),
    .done   (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [WIDTH-1:0] got,
                     input logic [WIDTH-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_q(input logic [WIDTH-1:0] v);
    enable = 2'b00;
    start  = 1'b0;
    load   = 1'b1;
    data   = v;
    tick();
    load   = 1'b0;
  endtask

  task automatic step1(input logic [1:0] en, input logic [AMT_W-1:0] a,
                       input logic [1:0] md);
    enable = en;
    amt    = a;
    mode   = md;
    tick();
    enable = 2'b00;
  endtask

  int busy_cnt;

  initial begin
    // Reset is asynchronous: outputs clear before any clock edge.
    #1 rst_n = 1'b0;
    #2;
    chk("rst_q",    q,            '0);
    chk("rst_busy", WIDTH'(busy), '0);
    chk("rst_done", WIDTH'(done), '0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // First edge after reset release already acts.
    load_q(ONE);
    chk("post_rst_load", q, ONE);

    // Manual rotate left / right.
    step1(2'b01, 7'd1, 2'b00);
    chk("rotl_1", q, WIDTH'(2));
    load_q(ONE);
    step1(2'b10, 7'd1, 2'b00);
    chk("rotr_1", q, ONE << 99);
    step1(2'b10, 7'd100, 2'b00);
    chk("rotr_100", q, ONE << 99);
    step1(2'b10, 7'd101, 2'b00);
    chk("rotr_101", q, ONE << 98);
    step1(2'b11, 7'd5, 2'b00);
    chk("hold_11", q, ONE << 98);

    // Automatic run of 3 steps, live inputs scrambled during RUN.
    load_q(ONE);
    start = 1'b1; steps = 8'd3; enable = 2'b01; amt = 7'd10; mode = 2'b00;
    tick();
    chk("run_cap_q",    q,            ONE);
    chk("run_cap_busy", WIDTH'(busy), ONE);
    enable = 2'b10; amt = 7'd3; mode = 2'b01; steps = 8'd50;
    tick();
    start = 1'b0;
    chk("run_s1_q",    q,            ONE << 10);
    chk("run_s1_busy", WIDTH'(busy), ONE);
    enable = 2'b11; amt = 7'd77; mode = 2'b10;
    tick();
    chk("run_s2_q",    q,            ONE << 20);
    chk("run_s2_busy", WIDTH'(busy), ONE);
    chk("run_s2_done", WIDTH'(done), '0);
    enable = 2'b10; amt = 7'd1;
    tick();
    enable = 2'b00;
    chk("run_s3_q",    q,            ONE << 30);
    chk("run_s3_busy", WIDTH'(busy), '0);
    chk("run_s3_done", WIDTH'(done), ONE);
    tick();
    chk("run_done_off", WIDTH'(done), '0);
    chk("run_idle_q",   q,            ONE << 30);

    // start with steps = 0: no move, immediate done.
    start = 1'b1; steps = 8'd0; enable = 2'b01; amt = 7'd1;
    tick();
    start = 1'b0; enable = 2'b00;
    chk("zero_q",    q,            ONE << 30);
    chk("zero_busy", WIDTH'(busy), '0);
    chk("zero_done", WIDTH'(done), ONE);
    tick();
    chk("zero_done_off", WIDTH'(done), '0);

`ifdef SHIFT_MODES_EN
    load_q(ONE << 99);
    step1(2'b10, 7'd4, 2'b10);
    chk("ash_r4", q, {5'b11111, 95'b0});
    load_q(ONE << 99);
    step1(2'b10, 7'd4, 2'b01);
    chk("lsh_r4", q, ONE << 95);
    load_q(ONE << 99);
    step1(2'b10, 7'd120, 2'b10);
    chk("ash_r120", q, ONES);
    load_q((ONE << 99) | ONE);
    step1(2'b01, 7'd1, 2'b10);
    chk("ash_l1", q, WIDTH'(2));
    load_q(ONE);
    step1(2'b10, 7'd1, 2'b01);
    chk("lsh_r1", q, '0);
    load_q(ONES);
    step1(2'b01, 7'd120, 2'b01);
    chk("lsh_l120", q, '0);
    load_q(ONE << 50);
    step1(2'b10, 7'd2, 2'b11);
    chk("mode11_rot", q, ONE << 48);
`else
    load_q(ONE << 99);
    step1(2'b10, 7'd4, 2'b01);
    chk("nomode_r4", q, ONE << 95);
    load_q(ONE);
    step1(2'b10, 7'd1, 2'b01);
    chk("nomode_r1", q, ONE << 99);
    load_q(ONE << 99);
    step1(2'b10, 7'd4, 2'b10);
    chk("nomode_ash", q, ONE << 95);
`endif

    // Load in the 4th RUN cycle aborts the run without done.
    load_q(ONE);
    start = 1'b1; steps = 8'd10; enable = 2'b01; amt = 7'd1; mode = 2'b00;
    tick();
    start = 1'b0; enable = 2'b00;
    repeat (3) tick();
    chk("abort_pre_q", q, ONE << 3);
    load = 1'b1; data = WIDTH'(8'hAB);
    tick();
    load = 1'b0;
    chk("abort_q",    q,            WIDTH'(8'hAB));
    chk("abort_busy", WIDTH'(busy), '0);
    chk("abort_done", WIDTH'(done), '0);
    tick();
    chk("abort_done2", WIDTH'(done), '0);
    chk("abort_hold",  q,            WIDTH'(8'hAB));

    // Reset mid-run clears immediately, no done afterwards.
    load_q(ONE);
    start = 1'b1; steps = 8'd10; enable = 2'b01; amt = 7'd1;
    tick();
    start = 1'b0; enable = 2'b00;
    repeat (2) tick();
    rst_n = 1'b0;
    #1;
    chk("mrst_q",    q,            '0);
    chk("mrst_busy", WIDTH'(busy), '0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    tick();
    chk("mrst_done", WIDTH'(done), '0);
    chk("mrst_busy2", WIDTH'(busy), '0);

    // Longest run: 255 steps of rotate-left by 1 -> 255 mod 100 = 55.
    load_q(ONE);
    start = 1'b1; steps = 8'd255; enable = 2'b01; amt = 7'd1; mode = 2'b00;
    tick();
    start = 1'b0; enable = 2'b00;
    busy_cnt = 0;
    for (int i = 0; i < 400; i++) begin
      if (!busy) break;
      busy_cnt++;
      tick();
    end
    chk("long_busy_cnt", WIDTH'(busy_cnt), WIDTH'(255));
    chk("long_done",     WIDTH'(done),     ONE);
    chk("long_q",        q,                ONE << 55);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
